// File: rtl/fuzz_round_ctrl_if.sv
// fuzz_round_ctrl_if: handshake and status bundle between the fuzz round controller and its harness.
interface fuzz_round_ctrl_if;
    logic        start;
    logic [63:0] tohost;
    logic [29:0] cov;
    logic        collect_ack;
    logic        collect_continue;
    logic        load_done;
    logic        dut_reset;
    logic        clk_hold;
    logic        collect_req;
    logic        load_req;
    logic        interrupt;
    logic [1:0]  status;
    logic [31:0] round_count;
    logic        busy;
    modport slave (
        input  start, tohost, cov, collect_ack, collect_continue, load_done,
        output dut_reset, clk_hold, collect_req, load_req, interrupt, status, round_count, busy
    );
    modport master (
        output start, tohost, cov, collect_ack, collect_continue, load_done,
        input  dut_reset, clk_hold, collect_req, load_req, interrupt, status, round_count, busy
    );
endinterface

// File: rtl/fuzz_round_ctrl.sv
// fuzz_round_ctrl: sequences fuzz rounds (reset, run, drain, collect, reload) with stall/watchdog interrupt.
module fuzz_round_ctrl #(
    parameter int unsigned MAX_CYCLES   = 20000000,
    parameter int unsigned STALL_BASE   = 1000,
    parameter int unsigned WATCHDOG     = 50000,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic             clock,
    input  logic             reset,
    fuzz_round_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RST, RUN, DRAIN, COLLECT, LOAD, DONE} state_t;
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, stall, stall_n, wd, wd_n, thr, round_n;
    logic [29:0] prev_cov;
    logic [1:0]  status_n;
    logic        run_n;
    always_comb begin
        state_n  = state;
        status_n = bus.status;
        round_n  = bus.round_count;
        case (state)
            IDLE:    state_n = bus.start ? RST : IDLE;
            RST:     state_n = cnt == RESET_CYCLES - 1 ? RUN : RST;
            RUN: begin
                if (bus.tohost[0] || cnt == MAX_CYCLES - 1) begin
                    state_n  = DRAIN;
                    status_n = bus.tohost[0] ? 2'd1 : 2'd2;
                end
            end
            DRAIN:   state_n = cnt == DRAIN_CYCLES - 1 ? COLLECT : DRAIN;
            COLLECT: begin
                if (bus.collect_ack) begin
                    state_n = bus.collect_continue ? LOAD : DONE;
                    round_n = bus.round_count + 32'd1;
                end
            end
            LOAD:    state_n = bus.load_done ? RST : LOAD;
            default: state_n = state;
        endcase
        run_n   = state == RUN && state_n == RUN;
        // One counter serves RST length, RUN cycles and DRAIN length; it restarts on every state change.
        cnt_n   = (state_n != state || !(state inside {RST, RUN, DRAIN})) ? '0 : cnt + 32'd1;
        stall_n = run_n && bus.cov == prev_cov ? stall + 32'd1 : '0;
        wd_n    = run_n ? wd + 32'd1 : '0;
        thr     = STALL_BASE * (32'(bus.cov[29:19]) + 32'd1);
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            stall           <= '0;
            wd              <= '0;
            prev_cov        <= '0;
            bus.dut_reset   <= 1'b1;
            bus.clk_hold    <= 1'b0;
            bus.collect_req <= 1'b0;
            bus.load_req    <= 1'b0;
            bus.interrupt   <= 1'b0;
            bus.status      <= 2'd0;
            bus.round_count <= '0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            stall           <= stall_n;
            wd              <= wd_n;
            prev_cov        <= bus.cov;
            bus.dut_reset   <= state_n inside {IDLE, RST, LOAD, DONE};
            bus.clk_hold    <= state_n inside {DRAIN, COLLECT, LOAD};
            bus.collect_req <= state_n == COLLECT;
            bus.load_req    <= state_n == LOAD;
            bus.interrupt   <= state_n == RUN && (stall_n >= thr || wd_n >= WATCHDOG);
            bus.status      <= status_n;
            bus.round_count <= round_n;
            bus.busy        <= !(state_n inside {IDLE, DONE});
        end
    end
endmodule

// File: tb/tb_fuzz_round_ctrl.sv
// tb_fuzz_round_ctrl: table-driven rounds with a status/round scoreboard plus reset corner sequences.
module tb_fuzz_round_ctrl;
    typedef struct {
        int          pass_at;
        logic [29:0] cov;
        int          flip_at;
        bit          inc;
        bit          cont;
        logic [1:0]  status;
        int          int_first;
        int          int_clear;
        int          run_len;
        int          rounds;
        int          loads;
    } vec_t;
    typedef struct {
        logic [1:0]  status;
        logic [31:0] rounds;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic load_q = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   load_pulses = 0;
    exp_t sb[$];
    vec_t tbl[5];
    fuzz_round_ctrl_if bus();
    fuzz_round_ctrl #(
        .MAX_CYCLES(100), .STALL_BASE(4), .WATCHDOG(50), .RESET_CYCLES(3), .DRAIN_CYCLES(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    always #5 clock = ~clock;
    always @(posedge clock) begin
        load_q <= bus.load_req;
        if (bus.load_req === 1'b1 && load_q === 1'b0) load_pulses <= load_pulses + 1;
    end
    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded 300000 ns");
        $fatal(1, "simulation time limit");
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask
    task automatic do_reset();
        bus.start = 1'b0;
        bus.tohost = '0;
        bus.cov = '0;
        bus.collect_ack = 1'b0;
        bus.collect_continue = 1'b0;
        bus.load_done = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        check1("rst_dut_reset", bus.dut_reset, 1'b1);
        check1("rst_clk_hold", bus.clk_hold, 1'b0);
        check1("rst_collect_req", bus.collect_req, 1'b0);
        check1("rst_load_req", bus.load_req, 1'b0);
        check1("rst_interrupt", bus.interrupt, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check32("rst_status", 32'(bus.status), 32'd0);
        check32("rst_round_count", bus.round_count, 32'd0);
        reset = 1'b1;
        tick();
        check1("idle_busy", bus.busy, 1'b0);
    endtask
    task automatic count_reset_high(output int n);
        n = 0;
        while (bus.dut_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask
    task automatic drain(input logic stray_ack, output int n);
        n = 0;
        bus.collect_ack = stray_ack;
        while (bus.clk_hold === 1'b1 && bus.collect_req !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        bus.collect_ack = 1'b0;
    endtask
    initial begin
        int   n, k, first, clr, load_base;
        exp_t e;
        tbl[0] = '{9,  30'h0,     -1, 1'b0, 1'b1, 2'd1, 4,  -1, 10,  1, 0};
        tbl[1] = '{-1, 30'h0,     -1, 1'b0, 1'b1, 2'd2, 4,  -1, 100, 2, 0};
        tbl[2] = '{99, 30'h80000, -1, 1'b0, 1'b0, 2'd1, 8,  -1, 100, 3, 2};
        tbl[3] = '{15, 30'h80000, 12, 1'b0, 1'b1, 2'd1, 8,  13, 16,  1, 0};
        tbl[4] = '{-1, 30'h100,   -1, 1'b1, 1'b0, 2'd2, 50, -1, 100, 2, 1};
        load_base = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || !tbl[i-1].cont) begin
                do_reset();
                load_base = load_pulses;
                bus.cov = tbl[i].cov;
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end else begin
                bus.cov = tbl[i].cov;
                bus.load_done = 1'b1;
                tick();
                bus.load_done = 1'b0;
            end
            e.status = tbl[i].status;
            e.rounds = 32'(tbl[i].rounds);
            sb.push_back(e);
            count_reset_high(n);
            check32($sformatf("rst_len[%0d]", i), n, 32'd3);
            k = 0;
            first = -1;
            clr = -1;
            while (bus.dut_reset === 1'b0 && bus.clk_hold === 1'b0 && k < 200) begin
                if (bus.interrupt === 1'b1 && first < 0) first = k;
                if (bus.interrupt === 1'b0 && first >= 0 && clr < 0) clr = k;
                bus.tohost = {$urandom, $urandom} & ~64'h1 | 64'(k == tbl[i].pass_at);
                bus.cov = tbl[i].inc ? tbl[i].cov + 30'(k + 1) :
                          (tbl[i].flip_at >= 0 && k >= tbl[i].flip_at) ? tbl[i].cov + 30'd1 : tbl[i].cov;
                bus.start = k == 2;
                bus.load_done = k == 3;
                tick();
                k++;
            end
            bus.tohost = '0;
            bus.start = 1'b0;
            bus.load_done = 1'b0;
            check32($sformatf("run_len[%0d]", i), k, tbl[i].run_len);
            check32($sformatf("int_first[%0d]", i), first, tbl[i].int_first);
            check32($sformatf("int_clear[%0d]", i), clr, tbl[i].int_clear);
            check1($sformatf("drain_irq[%0d]", i), bus.interrupt, 1'b0);
            drain(1'b1, n);
            check32($sformatf("drain_len[%0d]", i), n, 32'd5);
            check1($sformatf("collect_req[%0d]", i), bus.collect_req, 1'b1);
            check1($sformatf("collect_hold[%0d]", i), bus.clk_hold, 1'b1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard[%0d]: got empty queue want one entry", i);
                e.status = 2'd3;
                e.rounds = '1;
            end else begin
                e = sb.pop_front();
                check32($sformatf("status[%0d]", i), 32'(bus.status), 32'(e.status));
                check32($sformatf("rounds_pre_ack[%0d]", i), bus.round_count, e.rounds - 32'd1);
            end
            tick();
            tick();
            check1($sformatf("collect_wait[%0d]", i), bus.collect_req, 1'b1);
            bus.collect_ack = 1'b1;
            bus.collect_continue = tbl[i].cont;
            tick();
            bus.collect_ack = 1'b0;
            bus.collect_continue = 1'b0;
            check32($sformatf("round_count[%0d]", i), bus.round_count, e.rounds);
            check1($sformatf("collect_drop[%0d]", i), bus.collect_req, 1'b0);
            if (tbl[i].cont) begin
                check1($sformatf("load_req[%0d]", i), bus.load_req, 1'b1);
                check1($sformatf("load_dut_reset[%0d]", i), bus.dut_reset, 1'b1);
                check1($sformatf("load_hold[%0d]", i), bus.clk_hold, 1'b1);
                bus.collect_ack = 1'b1;
                tick();
                bus.collect_ack = 1'b0;
                tick();
                check32($sformatf("load_stray_ack[%0d]", i), bus.round_count, e.rounds);
                check1($sformatf("load_wait[%0d]", i), bus.load_req, 1'b1);
            end else begin
                check1($sformatf("done_busy[%0d]", i), bus.busy, 1'b0);
                check1($sformatf("done_dut_reset[%0d]", i), bus.dut_reset, 1'b1);
                check1($sformatf("done_hold[%0d]", i), bus.clk_hold, 1'b0);
                check1($sformatf("done_load_req[%0d]", i), bus.load_req, 1'b0);
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                tick();
                check1($sformatf("done_start_ignored[%0d]", i), bus.busy, 1'b0);
                check32($sformatf("load_pulses[%0d]", i), load_pulses - load_base, tbl[i].loads);
            end
        end
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        count_reset_high(n);
        repeat (6) tick();
        check1("run_irq_pre_reset", bus.interrupt, 1'b1);
        reset = 1'b0;
        tick();
        check1("run_reset_irq", bus.interrupt, 1'b0);
        check1("run_reset_dut_reset", bus.dut_reset, 1'b1);
        check1("run_reset_busy", bus.busy, 1'b0);
        reset = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        count_reset_high(n);
        bus.tohost = 64'h1;
        tick();
        bus.tohost = '0;
        drain(1'b0, n);
        check1("mid_collect_req", bus.collect_req, 1'b1);
        reset = 1'b0;
        tick();
        check1("mid_collect_req_reset", bus.collect_req, 1'b0);
        check1("mid_collect_hold", bus.clk_hold, 1'b0);
        check1("mid_collect_load_req", bus.load_req, 1'b0);
        check1("mid_collect_busy", bus.busy, 1'b0);
        check32("mid_collect_rounds", bus.round_count, 32'd0);
        check32("mid_collect_status", 32'(bus.status), 32'd0);
        reset = 1'b1;
        tick();
        check1("post_reset_idle", bus.busy, 1'b0);
        check32("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fuzz_round_ctrl.md
FUZZ_ROUND_CTRL -- requirements
Module: fuzz_round_ctrl

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 20000000: RUN cycles before a round is declared timed out.
REQ-002 SHALL have parameter STALL_BASE, default 1000: base coverage-stall threshold in cycles.
REQ-003 SHALL have parameter WATCHDOG, default 50000: RUN cycles without a pass before the interrupt is forced.
REQ-004 SHALL have parameter RESET_CYCLES, default 4: cycles dut_reset is held in RST.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 5: clock-hold settle cycles before collection.
REQ-006 SHALL have port clock, input, 1: rising-edge clock.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins the first round from IDLE.
REQ-009 SHALL have port tohost, input, 64: DUT host word; bit 0 set = round passed.
REQ-010 SHALL have port cov, input, 30: DUT coverage sum.
REQ-011 SHALL have port collect_ack, input, 1: coverage collector done.
REQ-012 SHALL have port collect_continue, input, 1: valid with collect_ack; 1 = run another round.
REQ-013 SHALL have port load_done, input, 1: testcase memory reload done.
REQ-014 SHALL have port dut_reset, output, 1: active-high DUT reset.
REQ-015 SHALL have port clk_hold, output, 1: DUT clock gate, 1 = clock held low.
REQ-016 SHALL have port collect_req, output, 1: request for coverage collection.
REQ-017 SHALL have port load_req, output, 1: request to reload the testcase.
REQ-018 SHALL have port interrupt, output, 1: stall/watchdog interrupt to the DUT msip.
REQ-019 SHALL have port status, output, 2: last round result (0 none, 1 pass, 2 timeout).
REQ-020 SHALL have port round_count, output, 32: completed rounds.
REQ-021 SHALL have port busy, output, 1: high in every state except IDLE and DONE.

Function
REQ-022 SHALL implement states IDLE, RST, RUN, DRAIN, COLLECT, LOAD, DONE; all outputs registered.
REQ-023 IDLE: dut_reset=1. On start, SHALL go to RST.
REQ-024 RST: dut_reset=1 for exactly RESET_CYCLES cycles, then SHALL go to RUN; the cycle counter, stall counter and watchdog clear on entry.
REQ-025 RUN: dut_reset=0, clk_hold=0; the cycle counter increments every cycle.
REQ-026 RUN: tohost[0]=1 SHALL set status=1 and go to DRAIN next cycle.
REQ-027 RUN: when the cycle counter reaches MAX_CYCLES, SHALL set status=2 and go to DRAIN.
REQ-028 If pass and timeout occur in the same cycle, pass SHALL win.
REQ-029 Stall counter: clears when cov differs from its registered previous value (the previous value updates at the same time), otherwise increments; it is held at 0 outside RUN.
REQ-030 Watchdog: increments in RUN, clears on tohost[0] or outside RUN.
REQ-031 interrupt SHALL be 1 in RUN when stall >= STALL_BASE*((cov>>19)+1) or watchdog >= WATCHDOG; the threshold is computed in 32 bits, unsigned; interrupt is 0 in all other states.
REQ-032 DRAIN: clk_hold=1 for DRAIN_CYCLES cycles, then SHALL go to COLLECT.
REQ-033 COLLECT: clk_hold=1, collect_req=1 until the collect_ack cycle inclusive; on ack, round_count increments (wrapping at 2^32).
REQ-034 On ack, SHALL go to LOAD if collect_continue=1, else to DONE.
REQ-035 LOAD: clk_hold=1, dut_reset=1, load_req=1 until load_done; then SHALL go to RST.
REQ-036 DONE: dut_reset=1, clk_hold=0; terminal until reset; start is ignored.
REQ-037 start outside IDLE SHALL be ignored; collect_ack outside COLLECT and load_done outside LOAD SHALL be ignored.

Reset
REQ-038 When reset=0 at a clock edge: state=IDLE, dut_reset=1, clk_hold=0, collect_req=0, load_req=0, interrupt=0, status=0, round_count=0, busy=0, all counters and previous-cov cleared.
REQ-039 Reset SHALL take priority over every transition, including reset asserted mid-RUN or mid-handshake; no request output remains high afterwards.

Verification (params MAX_CYCLES=100, STALL_BASE=4, WATCHDOG=50, RESET_CYCLES=3, DRAIN_CYCLES=5)
REQ-040 start; tohost=1 at RUN cycle 10 -> dut_reset high 3 cycles, status=1, clk_hold 5 cycles, then collect_req=1.
REQ-041 tohost held 0, cov constant -> interrupt=1 after 4 stalled cycles; status=2 after 100 RUN cycles.
REQ-042 cov=0x80000 constant -> interrupt at stall count 8; a cov change clears the interrupt next cycle.
REQ-043 tohost[0]=1 on the same cycle the cycle counter reaches 100 -> status=1.
REQ-044 Three rounds with collect_continue=1,1,0 -> round_count=3, final state DONE, busy=0, load_req pulsed twice.
REQ-045 reset=0 during COLLECT with collect_req=1 -> next cycle collect_req=0, state IDLE, round_count unchanged at 0 reset value.
